bc_fir_seq_ctrl: RTL and testbench

BC_FIR_SEQ_CTRL -- requirements
Module: bc_fir_seq_ctrl

---
 rtl/bc_fir_pkg.sv | 34 +++
 rtl/bc_fir_seq_ctrl_if.sv | 25 ++
 rtl/bc_fir_tap_buf.sv | 43 ++++
 rtl/bc_fir_seq_ctrl.sv | 118 +++++++++++
 tb/tb_bc_fir_seq_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/bc_fir_pkg.sv
// rtl/bc_fir_pkg.sv - shared widths, FSM state type and coefficient table for the folded FIR
package bc_fir_pkg;

  localparam int N_DEF      = 12;
  localparam int TAPS_DEF   = 39;
  localparam int HALF_DEF   = (TAPS_DEF + 1) / 2;
  localparam int DATA_W_DEF = N_DEF + 1;
  localparam int PAIR_W_DEF = N_DEF + 2;
  localparam int PROD_W_DEF = 2 * N_DEF + 2;
  localparam int ACC_W_DEF  = 2 * N_DEF + 8;

  // Left half plus centre tap; the right half is the mirror image.
  localparam int B_HALF [0:HALF_DEF-1] = '{
    0, 0, 2, 0, 5, 0, 11, 0, 23, 0,
    43, 0, 76, 0, 133, 0, 258, 0, 835, 1324
  };

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_HOLD = 2'd2
  } fir_state_e;

  function automatic int fir_coef(input int i);
    if (i >= 0 && i < HALF_DEF) begin
      return B_HALF[i];
    end
    if (i >= HALF_DEF && i < TAPS_DEF) begin
      return B_HALF[TAPS_DEF-1-i];
    end
    return 0;
  endfunction

endpackage

// File: rtl/bc_fir_seq_ctrl_if.sv
// rtl/bc_fir_seq_ctrl_if.sv - sample-in / result-out handshake bundle for the FIR sequencer
interface bc_fir_seq_ctrl_if
  import bc_fir_pkg::*;
#(
  parameter int N = N_DEF
);

  logic         in_valid;
  logic         in_ready;
  logic [N:0]   in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N:0]   out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/bc_fir_tap_buf.sv
// rtl/bc_fir_tap_buf.sv - circular sample store with one write port and two folded read ports
module bc_fir_tap_buf #(
  parameter int N    = 12,
  parameter int TAPS = 39,
  parameter int AW   = $clog2(TAPS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] wp_i,
  input  logic [N:0]    wdata_i,
  input  logic [AW-1:0] idx_i,
  output logic [N:0]    rd_a_o,
  output logic [N:0]    rd_b_o
);

  logic [N:0]    mem_q [0:TAPS-1];
  logic [AW:0]   sum_a;
  logic [AW:0]   sum_b;
  logic [AW-1:0] addr_a;
  logic [AW-1:0] addr_b;

  // Port a reads x[idx] at (wp-1-idx), port b reads x[TAPS-1-idx] at (wp+idx), both mod TAPS.
  always_comb begin
    sum_a  = {1'b0, wp_i} + (AW+1)'(TAPS - 1) - {1'b0, idx_i};
    sum_b  = {1'b0, wp_i} + {1'b0, idx_i};
    addr_a = (sum_a >= (AW+1)'(TAPS)) ? AW'(sum_a - (AW+1)'(TAPS)) : sum_a[AW-1:0];
    addr_b = (sum_b >= (AW+1)'(TAPS)) ? AW'(sum_b - (AW+1)'(TAPS)) : sum_b[AW-1:0];
    rd_a_o = mem_q[addr_a];
    rd_b_o = mem_q[addr_b];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[wp_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/bc_fir_seq_ctrl.sv
// rtl/bc_fir_seq_ctrl.sv - sequential symmetric FIR: one sample in, (TAPS+1)/2 folded MAC cycles, one result out
module bc_fir_seq_ctrl
  import bc_fir_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int TAPS = TAPS_DEF
) (
  input  logic                clock,
  input  logic                reset,
  bc_fir_seq_ctrl_if.slave    bus,
  output logic                busy
);

  localparam int AW     = $clog2(TAPS);
  localparam int PAIR_W = N + 2;
  localparam int PROD_W = 2 * N + 2;
  localparam int ACC_W  = 2 * N + 8;
  localparam int CENTER = (TAPS - 1) / 2;

  fir_state_e        state_q;
  logic [AW-1:0]     wp_q;
  logic [AW-1:0]     wp_d;
  logic [AW-1:0]     idx_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_d;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [N:0]        out_data_q;

  logic [N:0]        x_a;
  logic [N:0]        x_b;
  logic [PAIR_W-1:0] pair;
  logic [N-1:0]      coef;
  logic [PROD_W-1:0] prod;
  logic              accept;
  logic              at_centre;

  assign accept    = (state_q == S_IDLE) && in_ready_q && bus.in_valid;
  assign at_centre = (idx_q == AW'(CENTER));
  assign wp_d      = (wp_q == AW'(TAPS - 1)) ? '0 : wp_q + AW'(1);

  // The centre tap has no partner, so only x[idx] contributes there.
  always_comb begin
    pair  = {1'b0, x_a} + (at_centre ? {PAIR_W{1'b0}} : {1'b0, x_b});
    coef  = N'(fir_coef(int'(idx_q)));
    prod  = {{(N+2){1'b0}}, coef} * {{N{1'b0}}, pair};
    acc_d = acc_q + {{(ACC_W-PROD_W){1'b0}}, prod};
  end

  bc_fir_tap_buf #(
    .N    (N),
    .TAPS (TAPS),
    .AW   (AW)
  ) u_tap_buf (
    .clock   (clock),
    .reset   (reset),
    .we_i    (accept),
    .wp_i    (wp_q),
    .wdata_i (bus.in_data),
    .idx_i   (idx_q),
    .rd_a_o  (x_a),
    .rd_b_o  (x_b)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wp_q        <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            wp_q       <= wp_d;
            idx_q      <= '0;
            acc_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_MAC;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        S_MAC: begin
          acc_q <= acc_d;
          if (at_centre) begin
            state_q <= S_HOLD;
          end else begin
            idx_q <= idx_q + AW'(1);
          end
        end
        S_HOLD: begin
          // First HOLD cycle registers the result; it then stays put until taken.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_data_q  <= acc_q[N:0];
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_bc_fir_seq_ctrl.sv
// tb/tb_bc_fir_seq_ctrl.sv - directed bench for bc_fir_seq_ctrl against a direct-form convolution model
module tb_bc_fir_seq_ctrl;

  localparam int N    = 12;
  localparam int TAPS = 39;

  localparam int BC [0:TAPS-1] = '{
    0, 0, 2, 0, 5, 0, 11, 0, 23, 0, 43, 0, 76, 0, 133, 0, 258, 0, 835, 1324,
    835, 0, 258, 0, 133, 0, 76, 0, 43, 0, 23, 0, 11, 0, 5, 0, 2, 0, 0
  };

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic busy;

  bc_fir_seq_ctrl_if #(.N(N)) bus ();

  bc_fir_seq_ctrl #(
    .N    (N),
    .TAPS (TAPS)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int hist [0:TAPS-1];
  int r;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_hist();
    for (int k = 0; k < TAPS; k++) hist[k] = 0;
  endtask

  task automatic push_hist(input int v);
    for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = v;
  endtask

  function automatic int model_out();
    int s;
    s = 0;
    for (int k = 0; k < TAPS; k++) s += BC[k] * hist[k];
    return s % 8192;
  endfunction

  // Offer one sample, measure latency, check the result, optionally hold out_ready low.
  task automatic run_sample(input int v, input int hold, output int res);
    int  lat;
    bit  ok;
    res = -1;
    ok  = 0;
    for (int w = 0; w < 50; w++) begin
      @(negedge clock);
      if (bus.in_ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      check("in_ready_timeout", 32'd0, 32'd1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 13'(v);
    @(posedge clock);
    push_hist(v);
    @(negedge clock);
    bus.in_valid = 1'b0;
    lat = 0;
    ok  = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (bus.out_valid === 1'b1) begin
        ok = 1;
        break;
      end
    end
    check("latency", 32'(lat), 32'd21);
    if (!ok) return;
    check("out_data", 32'(bus.out_data), 32'(model_out()));
    res = int'(bus.out_data);
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 13'(h * 1000 + 7);
      @(posedge clock);
      @(negedge clock);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_out_stable", 32'(bus.out_data), 32'(res));
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.out_ready = 1'b0;
    check("in_ready_after_take", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic impulse_run(input string tag);
    for (int i = 0; i < 46; i++) begin
      run_sample((i == 0) ? 1 : 0, 0, r);
      if (i == 18) check({tag, "_tap18"}, 32'(r), 32'd835);
      if (i == 19) check({tag, "_centre"}, 32'(r), 32'd1324);
      if (i == 38) check({tag, "_tap38"}, 32'(r), 32'd0);
      if (i == 45) check({tag, "_tail"}, 32'(r), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    clear_hist();

    repeat (3) @(negedge clock);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("in_ready_first_edge", 32'(bus.in_ready), 32'd1);

    impulse_run("impulse");

    for (int i = 0; i < 39; i++) run_sample(1, 0, r);
    check("step_39th", 32'(r), 32'd4096);
    run_sample(1, 5, r);
    check("step_bp", 32'(r), 32'd4096);
    run_sample(1, 0, r);
    check("step_after_bp", 32'(r), 32'd4096);

    for (int i = 0; i < 39; i++) run_sample(8191, 0, r);
    check("overflow_39th", 32'(r), 32'd4096);

    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_data  = 13'd1;
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clock);
    @(negedge clock);
    check("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("midmac_busy", 32'(busy), 32'd0);
    check("midmac_out_valid", 32'(bus.out_valid), 32'd0);
    check("midmac_out_data", 32'(bus.out_data), 32'd0);
    check("midmac_in_ready", 32'(bus.in_ready), 32'd0);
    clear_hist();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("in_ready_after_rst2", 32'(bus.in_ready), 32'd1);

    impulse_run("impulse2");

    for (int i = 0; i < 100; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      run_sample(int'($urandom_range(0, 8191)), 0, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
